// File: rtl/asm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asm_ctrl_pkg
// Purpose  : Shared state encoding and default sizes for the event counter.
// Revision : 1.0 - initial release
// ============================================================================
package asm_ctrl_pkg;

    // One-hot state encoding; IDLE/ARM/RUN correspond to legacy T0/T1/T2.
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_ARM  = 3'b010;
    localparam logic [2:0] ST_RUN  = 3'b100;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_TIMEOUT = 16;

    function automatic logic is_busy(input logic [2:0] st);
        return (st != ST_IDLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/asm_event_counter_sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_counter
// Purpose  : Wrapping up-counter with synchronous clear and count enable.
// Revision : 1.0 - initial release
// ============================================================================
module sync_counter
    import asm_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over enable; the add wraps naturally at 2^WIDTH.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q_o = count_q;

endmodule
`default_nettype wire

// File: rtl/asm_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : asm_event_counter
// Purpose  : Start/count/done sequencer counting qualified X events up to TC.
//            Optional ARM idle-timeout abort enabled by ASM_CNT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module asm_event_counter
    import asm_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EDGE_MODE = 0,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             S,
    input  logic             X,
    input  logic [WIDTH-1:0] TC,
    output logic [WIDTH-1:0] Q,
    output logic             G,
    output logic             busy,
    output logic             err
);

    localparam logic c_EDGE = (EDGE_MODE != 0);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             x_q;
    logic             g_q, g_d;
    logic             x_evt;
    logic             z;
    logic             cnt_clr;
    logic             cnt_en;
    logic             timeout_hit;

    // In level mode the history term is masked off, so X alone qualifies.
    assign x_evt = X & ~(x_q & c_EDGE);
    assign z     = (Q == tc_q);

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        g_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (S) begin
                    cnt_clr = 1'b1;
                    tc_d    = TC;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (x_evt) begin
                    cnt_en  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Done has priority over a coincident event.
                if (z) begin
                    g_d     = 1'b1;
                    state_d = ST_IDLE;
                end else if (x_evt) begin
                    cnt_en  = 1'b1;
                end else begin
                    state_d = ST_ARM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tc_q    <= '0;
            x_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            x_q     <= X;
            g_q     <= g_d;
        end
    end

`ifdef ASM_CNT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          err_q, err_d;

    assign timeout_hit = (state_q == ST_ARM) && (idle_q == IW'(TIMEOUT));
    assign err_d       = timeout_hit;

    always_comb begin
        idle_d = idle_q;
        if (((state_d == ST_ARM) && (state_q != ST_ARM)) || x_evt || err_d) begin
            idle_d = '0;
        end else if (state_q == ST_ARM) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    sync_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk_i  (CLK),
        .rst_ni (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .q_o    (Q)
    );

    assign G    = g_q;
    assign busy = is_busy(state_q);

endmodule
`default_nettype wire

// File: tb/tb_asm_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_asm_event_counter
// Purpose  : Scoreboard bench for asm_event_counter (level and edge instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_asm_event_counter;

    typedef struct {
        string      name;
        int         sel;   // 0: level DUT, 1: edge DUT, 2: both
        logic [3:0] q;
        logic       g;
        logic       b;
        logic       e;
    } exp_t;

    logic       CLK   = 1'b0;
    logic       rst_n = 1'b0;
    logic       S     = 1'b0;
    logic       X     = 1'b0;
    logic [3:0] TC    = 4'd0;

    logic [3:0] q0, q1;
    logic       g0, g1, b0, b1, e0, e1;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    asm_event_counter #(.WIDTH(4), .EDGE_MODE(0), .TIMEOUT(8)) u_lvl (
        .CLK(CLK), .rst_n(rst_n), .S(S), .X(X), .TC(TC),
        .Q(q0), .G(g0), .busy(b0), .err(e0)
    );

    asm_event_counter #(.WIDTH(4), .EDGE_MODE(1), .TIMEOUT(15)) u_edg (
        .CLK(CLK), .rst_n(rst_n), .S(S), .X(X), .TC(TC),
        .Q(q1), .G(g1), .busy(b1), .err(e1)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cmp(input string name, input int dut,
                       input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got q=%0d g=%b busy=%b err=%b, want q=%0d g=%b busy=%b err=%b",
                     name, dut, act[6:3], act[2], act[1], act[0],
                     exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: one expectation per sample point (clock edge or reset assertion).
    initial begin
        exp_t ex;
        forever begin
            @(posedge CLK or negedge rst_n);
            #1;
            if (sb.size() > 0) begin
                ex = sb.pop_front();
                if (ex.sel == 0 || ex.sel == 2)
                    cmp(ex.name, 0, {q0, g0, b0, e0}, {ex.q, ex.g, ex.b, ex.e});
                if (ex.sel == 1 || ex.sel == 2)
                    cmp(ex.name, 1, {q1, g1, b1, e1}, {ex.q, ex.g, ex.b, ex.e});
            end
        end
    end

    task automatic step(input logic s, input logic x, input logic [3:0] tc,
                        input int sel, input logic [3:0] q, input logic g,
                        input logic b, input logic e, input string name);
        exp_t ex;
        @(negedge CLK);
        S  = s;
        X  = x;
        TC = tc;
        if (sel >= 0) begin
            ex = '{name, sel, q, g, b, e};
            sb.push_back(ex);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        S     = 1'b0;
        X     = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t ex;

        // Reset state, checked while reset is held
        step(0, 0, 0, 2, 0, 0, 0, 0, "reset");
        @(negedge CLK);
        rst_n = 1'b1;

        // 1: async reset in the middle of a run
        step(1, 0, 9, 0, 0, 0, 1, 0, "t1_start");
        for (int k = 1; k <= 5; k++) step(0, 1, 9, 0, 4'(k), 0, 1, 0, "t1_cnt");
        @(negedge CLK);
        #1;
        ex = '{"t1_async_rst", 2, 4'd0, 1'b0, 1'b0, 1'b0};
        sb.push_back(ex);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 6; k <= 12; k++) step(0, 1, 9, 0, 0, 0, 0, 0, "t1_post");

        // 2: level mode, continuous events to TC=15
        do_reset();
        step(1, 1, 15, 0, 0, 0, 1, 0, "t2_start");
        for (int k = 1; k <= 15; k++) step(0, 1, 15, 0, 4'(k), 0, 1, 0, "t2_cnt");
        step(0, 1, 15, 0, 15, 1, 0, 0, "t2_done");
        step(0, 1, 15, 0, 15, 0, 0, 0, "t2_gclr");

        // 3: gapped events, restarts while busy ignored, restart during G accepted
        do_reset();
        step(1, 0, 3, 0, 0, 0, 1, 0, "t3_start");
        step(1, 1, 7, 0, 1, 0, 1, 0, "t3_e1");
        step(1, 0, 7, 0, 1, 0, 1, 0, "t3_gap1");
        step(1, 1, 7, 0, 2, 0, 1, 0, "t3_e2");
        step(1, 0, 7, 0, 2, 0, 1, 0, "t3_gap2");
        step(1, 1, 7, 0, 3, 0, 1, 0, "t3_e3");
        step(0, 0, 7, 0, 3, 1, 0, 0, "t3_done");
        step(1, 1, 2, 0, 0, 0, 1, 0, "t3_restart_on_g");
        step(0, 1, 7, 0, 1, 0, 1, 0, "t3_r1");
        step(0, 1, 7, 0, 2, 0, 1, 0, "t3_r2");
        step(0, 1, 7, 0, 2, 1, 0, 0, "t3_rdone");
        step(0, 0, 7, 0, 2, 0, 0, 0, "t3_rgclr");

        // 4: edge mode, X high 10, low 2, high 3 with TC=2
        do_reset();
        step(1, 0, 2, 1, 0, 0, 1, 0, "t4_start");
        step(0, 1, 2, 1, 1, 0, 1, 0, "t4_rise1");
        for (int k = 2; k <= 10; k++) step(0, 1, 2, 1, 1, 0, 1, 0, "t4_hold");
        for (int k = 11; k <= 12; k++) step(0, 0, 2, 1, 1, 0, 1, 0, "t4_low");
        step(0, 1, 2, 1, 2, 0, 1, 0, "t4_rise2");
        step(0, 1, 2, 1, 2, 1, 0, 0, "t4_done");
        step(0, 1, 2, 1, 2, 0, 0, 0, "t4_gclr");

        // 5: TC=0 completes after 16 events via wrap
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1, 0, "t5_start");
        for (int k = 1; k <= 15; k++) step(0, 1, 0, 0, 4'(k), 0, 1, 0, "t5_cnt");
        step(0, 1, 0, 0, 0, 0, 1, 0, "t5_wrap");
        step(0, 1, 0, 0, 0, 1, 0, 0, "t5_done");
        step(0, 0, 0, 0, 0, 0, 0, 0, "t5_gclr");

        // 6: ARM with no events
        do_reset();
        step(1, 0, 5, 0, 0, 0, 1, 0, "t6_start");
`ifdef ASM_CNT_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) step(0, 0, 5, 0, 0, 0, 1, 0, "t6_arm");
        step(0, 0, 5, 0, 0, 0, 0, 1, "t6_err");
        step(0, 0, 5, 0, 0, 0, 0, 0, "t6_errclr");
`else
        for (int k = 1; k <= 10; k++) step(0, 0, 5, 0, 0, 0, 1, 0, "t6_wait");
`endif

        @(negedge CLK);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
